fb_clear_writer: RTL and testbench

//  Downstream consumer of the clear-screen raster coordinate generator. On start, turns its (x,y) stream

---
 rtl/fb_pkg.sv | 12 +
 rtl/fb_clear_writer_if.sv | 15 +
 rtl/fb_addr_calc.sv | 22 ++
 rtl/fb_clear_writer.sv | 128 ++++++++++++
 tb/tb_fb_clear_writer.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fb_pkg.sv
// Shared defaults and types for the framebuffer clear path.
package fb_pkg;

  localparam int HACTIVE_DEF = 1280;
  localparam int VACTIVE_DEF = 640;
  localparam int PIXEL_W     = 24;

  typedef enum logic [2:0] {IDLE, INIT, FILL, DRAIN, DONE} clr_state_t;

  typedef logic [PIXEL_W-1:0] pixel_t;

endpackage

// File: rtl/fb_clear_writer_if.sv
// Framebuffer write-beat port (valid/ready) from a writer to the memory arbiter.
interface fb_clear_writer_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 24
);

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (output wr_valid, wr_addr, wr_data, input wr_ready);
  modport slave  (input wr_valid, wr_addr, wr_data, output wr_ready);

endinterface

// File: rtl/fb_addr_calc.sv
// Linear framebuffer address y*HACTIVE + x, truncated to ADDR_W bits; shared with the draw path.
module fb_addr_calc #(
  parameter int WIDTH   = 11,
  parameter int HACTIVE = 1280,
  parameter int ADDR_W  = 20
) (
  input  logic [WIDTH-1:0]  x,
  input  logic [WIDTH-1:0]  y,
  output logic [ADDR_W-1:0] addr
);

  // Full-width product first so truncation is a plain modulo 2**ADDR_W.
  localparam int PW = ADDR_W + 2*WIDTH;

  logic [PW-1:0] full;
  logic          unused_hi;

  assign full      = PW'(y) * PW'(HACTIVE) + PW'(x);
  assign addr      = full[ADDR_W-1:0];
  assign unused_hi = ^full[PW-1:ADDR_W];

endmodule

// File: rtl/fb_clear_writer.sv
// Turns the raster generator's (x,y) stream into framebuffer clear beats.
// CLEAR_PATTERN_EN: when defined, beats carry a colour/~colour checkerboard instead of a flat fill.
module fb_clear_writer
  import fb_pkg::*;
#(
  parameter int WIDTH   = 11,
  parameter int HACTIVE = HACTIVE_DEF,
  parameter int VACTIVE = VACTIVE_DEF,
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = PIXEL_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] color,
  input  logic [WIDTH-1:0]  x_in,
  input  logic [WIDTH-1:0]  y_in,
  output logic              coord_en,
  output logic              gen_clr,
  output logic              busy,
  output logic              done,
  fb_clear_writer_if.master wr
);

  clr_state_t        state, state_d;
  logic              abort_q, abort_d;
  logic [DATA_W-1:0] color_q;
  logic [DATA_W-1:0] pix_data;
  logic [ADDR_W-1:0] pix_addr;
  logic              vld_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              load, accept, last_px;

  fb_addr_calc #(.WIDTH(WIDTH), .HACTIVE(HACTIVE), .ADDR_W(ADDR_W)) u_addr (
    .x    (x_in),
    .y    (y_in),
    .addr (pix_addr)
  );

`ifdef CLEAR_PATTERN_EN
  assign pix_data = (x_in[0] ^ y_in[0]) ? ~color_q : color_q;
`else
  assign pix_data = color_q;
`endif

  assign accept  = vld_q & wr.wr_ready;
  assign last_px = (x_in == WIDTH'(HACTIVE-1)) && (y_in == WIDTH'(VACTIVE-1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      abort_q <= 1'b0;
    end else begin
      state   <= state_d;
      abort_q <= abort_d;
    end
  end

  // abort_q remembers an aborted run so DRAIN skips the done pulse.
  always_comb begin
    state_d = state;
    abort_d = abort_q;
    unique case (state)
      IDLE: if (start) begin
        state_d = INIT;
        abort_d = 1'b0;
      end
      INIT: if (abort) begin
        state_d = DRAIN;
        abort_d = 1'b1;
      end else begin
        state_d = FILL;
      end
      FILL: if (abort) begin
        state_d = DRAIN;
        abort_d = 1'b1;
      end else if (load && last_px) begin
        state_d = DRAIN;
      end
      DRAIN: if (!vld_q || accept) state_d = abort_q ? IDLE : DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load     = 1'b0;
    coord_en = 1'b0;
    gen_clr  = 1'b0;
    done     = 1'b0;
    busy     = (state != IDLE);
    unique case (state)
      INIT: gen_clr = 1'b1;
      FILL: begin
        load     = !abort && (!vld_q || wr.wr_ready);
        coord_en = load && !last_px;
      end
      DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Single output register: reloads on the accept edge so full-rate beats have no bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      color_q <= '0;
    end else begin
      if (state == IDLE && start) color_q <= color;
      if (load) begin
        vld_q  <= 1'b1;
        addr_q <= pix_addr;
        data_q <= pix_data;
      end else if (accept) begin
        vld_q  <= 1'b0;
      end
    end
  end

  assign wr.wr_valid = vld_q;
  assign wr.wr_addr  = addr_q;
  assign wr.wr_data  = data_q;

endmodule

// File: tb/tb_fb_clear_writer.sv
// Scoreboard bench for fb_clear_writer on a 4x4 frame with a behavioural coordinate generator.
module tb_fb_clear_writer;

  localparam int WIDTH   = 11;
  localparam int HACTIVE = 4;
  localparam int VACTIVE = 4;
  localparam int ADDR_W  = 4;
  localparam int DATA_W  = 24;
  localparam int NPIX    = HACTIVE * VACTIVE;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } beat_t;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [DATA_W-1:0] color = '0;
  logic [WIDTH-1:0]  x_in, y_in;
  logic              coord_en, gen_clr, busy, done;
  logic              ready_rand = 1'b0;

  fb_clear_writer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) wr ();

  fb_clear_writer #(
    .WIDTH(WIDTH), .HACTIVE(HACTIVE), .VACTIVE(VACTIVE), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .color    (color),
    .x_in     (x_in),
    .y_in     (y_in),
    .coord_en (coord_en),
    .gen_clr  (gen_clr),
    .busy     (busy),
    .done     (done),
    .wr       (wr.master)
  );

  always #5 clk = ~clk;

  // Raster generator model
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_in <= '0;
      y_in <= '0;
    end else if (gen_clr) begin
      x_in <= '0;
      y_in <= '0;
    end else if (coord_en) begin
      if (x_in == WIDTH'(HACTIVE-1)) begin
        x_in <= '0;
        y_in <= (y_in == WIDTH'(VACTIVE-1)) ? '0 : y_in + WIDTH'(1);
      end else begin
        x_in <= x_in + WIDTH'(1);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    wr.wr_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  beat_t exp_q[$];
  int n_cmp = 0, n_err = 0;
  int cyc = 0, acc_cnt = 0, done_cnt = 0, coord_cnt = 0;
  int last_acc_cyc = -1, done_cyc = -1, busy_fall_cyc = -1;
  logic  hold_v = 1'b0, busy_prev = 1'b0;
  beat_t hold_b;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] exp_data(input int i, input logic [DATA_W-1:0] c);
`ifdef CLEAR_PATTERN_EN
    return ((((i % HACTIVE) ^ (i / HACTIVE)) & 1) != 0) ? ~c : c;
`else
    return (i >= 0) ? c : c;
`endif
  endfunction

  // Monitor: pops the scoreboard on every accepted beat, checks hold while stalled.
  always @(negedge clk) begin
    beat_t b;
    if (!reset) begin
      hold_v    = 1'b0;
      busy_prev = 1'b0;
    end else begin
      if (hold_v) begin
        check("hold_valid", 32'(wr.wr_valid), 1);
        check("hold_beat", 32'({wr.wr_addr, wr.wr_data}), 32'(hold_b));
      end
      if (wr.wr_valid && wr.wr_ready) begin
        acc_cnt++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_beat: got addr %0h data %0h expected none", wr.wr_addr, wr.wr_data);
        end else begin
          b = exp_q.pop_front();
          check("beat_addr", 32'(wr.wr_addr), 32'(b.addr));
          check("beat_data", 32'(wr.wr_data), 32'(b.data));
        end
        if (wr.wr_addr == ADDR_W'(NPIX-1)) last_acc_cyc = cyc;
      end
      hold_v    = wr.wr_valid && !wr.wr_ready;
      hold_b    = {wr.wr_addr, wr.wr_data};
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (coord_en) coord_cnt++;
      if (busy_prev && !busy) busy_fall_cyc = cyc;
      busy_prev = busy;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [DATA_W-1:0] c, input int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.addr = ADDR_W'(i);
      b.data = exp_data(i, c);
      exp_q.push_back(b);
    end
  endtask

  // Leaves the bench in the cycle after start was sampled (DUT in INIT).
  task automatic do_start(input logic [DATA_W-1:0] c);
    tick();
    start = 1'b1;
    color = c;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 400; i++) begin
      tick();
      if (!busy) break;
    end
    @(negedge clk);
    #1;
    check(name, 32'(busy), 0);
  endtask

  int a0, d0, c0;

  initial begin
    repeat (3) tick();
    check("rst_wr_valid", 32'(wr.wr_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_coord_en", 32'(coord_en), 0);
    check("rst_gen_clr", 32'(gen_clr), 0);
    reset = 1'b1;
    tick();

    // Full-rate frame
    a0 = acc_cnt; d0 = done_cnt; c0 = coord_cnt;
    push_frame(24'h00FF00, NPIX);
    do_start(24'h00FF00);
    check("t2_gen_clr", 32'(gen_clr), 1);
    check("t2_busy", 32'(busy), 1);
    tick();
    check("t2_valid_fill0", 32'(wr.wr_valid), 0);
    tick();
    check("t2_valid_first", 32'(wr.wr_valid), 1);
    check("t2_addr_first", 32'(wr.wr_addr), 0);
    wait_idle("t2_busy_fall");
    check("t2_accepts", acc_cnt - a0, NPIX);
    check("t2_done_cnt", done_cnt - d0, 1);
    check("t2_coord_cnt", coord_cnt - c0, NPIX - 1);
    check("t2_done_lat", done_cyc - last_acc_cyc, 1);
    check("t2_busy_lat", busy_fall_cyc - done_cyc, 1);
    check("t2_q_empty", exp_q.size(), 0);

    // Reset mid-FILL
    push_frame(24'h123456, NPIX);
    do_start(24'h123456);
    repeat (5) tick();
    #2 reset = 1'b0;
    #1;
    check("t1_wr_valid", 32'(wr.wr_valid), 0);
    check("t1_busy", 32'(busy), 0);
    check("t1_done", 32'(done), 0);
    check("t1_coord_en", 32'(coord_en), 0);
    exp_q.delete();
    tick();
    reset = 1'b1;
    tick();
    check("t1_idle_busy", 32'(busy), 0);
    check("t1_idle_valid", 32'(wr.wr_valid), 0);

    // Random backpressure
    a0 = acc_cnt; d0 = done_cnt;
    ready_rand = 1'b1;
    push_frame(24'hABCDEF, NPIX);
    do_start(24'hABCDEF);
    wait_idle("t3_busy_fall");
    ready_rand = 1'b0;
    check("t3_accepts", acc_cnt - a0, NPIX);
    check("t3_done_cnt", done_cnt - d0, 1);
    check("t3_q_empty", exp_q.size(), 0);

    // Abort after the 5th accept: beat 5 is already loaded and must drain
    tick();
    a0 = acc_cnt; d0 = done_cnt; c0 = coord_cnt;
    push_frame(24'h0F0F0F, 6);
    do_start(24'h0F0F0F);
    for (int i = 0; i < 100; i++) begin
      tick();
      if (acc_cnt - a0 >= 5) break;
    end
    abort = 1'b1;
    wait_idle("t4_busy_fall");
    abort = 1'b0;
    check("t4_accepts", acc_cnt - a0, 6);
    check("t4_done_cnt", done_cnt - d0, 0);
    check("t4_coord_cnt", coord_cnt - c0, 6);
    check("t4_q_empty", exp_q.size(), 0);

    // Start during FILL is ignored; restart after done
    a0 = acc_cnt; d0 = done_cnt;
    push_frame(24'h336699, NPIX);
    do_start(24'h336699);
    repeat (6) tick();
    start = 1'b1;
    color = 24'hFFFFFF;
    tick();
    start = 1'b0;
    wait_idle("t5_busy_fall");
    check("t5_accepts", acc_cnt - a0, NPIX);
    check("t5_done_cnt", done_cnt - d0, 1);
    a0 = acc_cnt;
    push_frame(24'h777777, NPIX);
    do_start(24'h777777);
    wait_idle("t5_busy_fall2");
    check("t5_accepts2", acc_cnt - a0, NPIX);
    check("t5_q_empty", exp_q.size(), 0);

    // start and abort together: start wins, abort then ends the run with no beats
    a0 = acc_cnt; d0 = done_cnt;
    tick();
    abort = 1'b1;
    start = 1'b1;
    color = 24'h111111;
    tick();
    start = 1'b0;
    check("t7_busy", 32'(busy), 1);
    wait_idle("t7_busy_fall");
    abort = 1'b0;
    check("t7_accepts", acc_cnt - a0, 0);
    check("t7_done_cnt", done_cnt - d0, 0);

    // Black clear: checkerboard pattern visible when the pattern build is enabled
    a0 = acc_cnt;
    push_frame(24'h000000, NPIX);
    do_start(24'h000000);
    wait_idle("t6_busy_fall");
    check("t6_accepts", acc_cnt - a0, NPIX);
    check("t6_q_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "watchdog");
  end

endmodule
